// File: rtl/uart_dbg_pkg.sv
// Shared constants, state encoding and frame lengths for the UART hex debug reporter.
// Frame lengths for both the plain and the UART_HEX_REPORTER_ECHO_EN build live here.
package uart_dbg_pkg;

    localparam logic [7:0] CMD_PC_DEFAULT   = 8'h50;
    localparam logic [7:0] CMD_INST_DEFAULT = 8'h49;
    localparam logic [7:0] CMD_ALU_DEFAULT  = 8'h41;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

    // Wide enough for the longest frame of either build (12 characters).
    localparam int IDX_W = 4;

    localparam logic [IDX_W-1:0] FRAME_LEN_KNOWN        = 4'd10;
    localparam logic [IDX_W-1:0] FRAME_LEN_UNKNOWN      = 4'd3;
    localparam logic [IDX_W-1:0] FRAME_LEN_KNOWN_ECHO   = 4'd12;
    localparam logic [IDX_W-1:0] FRAME_LEN_UNKNOWN_ECHO = 4'd5;
    localparam logic [IDX_W-1:0] ECHO_PREFIX_LEN        = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_SEND   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational encoder from a 4-bit value to its uppercase ASCII hex digit.
module hex_nibble_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            // 8'h37 + 10 lands on 'A'.
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/uart_hex_reporter.sv
// Debug responder: one command byte in, one probe streamed out as ASCII hex + CR LF.
// Define UART_HEX_REPORTER_ECHO_EN to prefix each response with "<cmd>:".
// Handshake: rx_re pulses for one cycle to consume rx_data; tx_we pulses for one
// cycle with tx_data only while tx_busy is low; tx_busy is ignored in the GAP cycle.
module uart_hex_reporter
    import uart_dbg_pkg::*;
#(
    parameter logic [7:0] CMD_PC   = CMD_PC_DEFAULT,
    parameter logic [7:0] CMD_INST = CMD_INST_DEFAULT,
    parameter logic [7:0] CMD_ALU  = CMD_ALU_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_re,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_we,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    input  logic [31:0] alu_in,
    output logic        busy,
    output logic        cmd_err,
    output logic [7:0]  cmd_count,
    output state_t      dbg_state
);

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         cmd_q;
    logic [31:0]        snap_q;
    logic               unknown_q;
    logic [IDX_W-1:0]   idx_q;
    logic [7:0]         tx_data_q;
    logic [7:0]         cmd_count_q;

    logic               cmd_known;
    logic [IDX_W-1:0]   frame_len;
    logic [IDX_W-1:0]   body_idx;
    logic               last_char;
    logic [3:0]         nibble;
    logic [7:0]         hex_char;
    logic [7:0]         cur_char;

    assign cmd_known = (cmd_q == CMD_PC) || (cmd_q == CMD_INST) || (cmd_q == CMD_ALU);

`ifdef UART_HEX_REPORTER_ECHO_EN
    assign frame_len = unknown_q ? FRAME_LEN_UNKNOWN_ECHO : FRAME_LEN_KNOWN_ECHO;
    assign body_idx  = idx_q - ECHO_PREFIX_LEN;
`else
    assign frame_len = unknown_q ? FRAME_LEN_UNKNOWN : FRAME_LEN_KNOWN;
    assign body_idx  = idx_q;
`endif

    assign last_char = (idx_q == frame_len - 4'd1);

    always_comb begin
        nibble = snap_q[31:28];
        case (body_idx[2:0])
            3'd0: nibble = snap_q[31:28];
            3'd1: nibble = snap_q[27:24];
            3'd2: nibble = snap_q[23:20];
            3'd3: nibble = snap_q[19:16];
            3'd4: nibble = snap_q[15:12];
            3'd5: nibble = snap_q[11:8];
            3'd6: nibble = snap_q[7:4];
            default: nibble = snap_q[3:0];
        endcase
    end

    hex_nibble_ascii u_hex (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    always_comb begin
        cur_char = ASCII_LF;
        if (unknown_q) begin
            if (body_idx == 4'd0)      cur_char = ASCII_QMARK;
            else if (body_idx == 4'd1) cur_char = ASCII_CR;
            else                       cur_char = ASCII_LF;
        end else begin
            if (body_idx < 4'd8)       cur_char = hex_char;
            else if (body_idx == 4'd8) cur_char = ASCII_CR;
            else                       cur_char = ASCII_LF;
        end
`ifdef UART_HEX_REPORTER_ECHO_EN
        if (idx_q == 4'd0)      cur_char = cmd_q;
        else if (idx_q == 4'd1) cur_char = ASCII_COLON;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (rx_valid) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_SEND;
            ST_SEND:   if (!tx_busy) state_d = ST_GAP;
            ST_GAP:    state_d = (idx_q == frame_len) ? ST_IDLE : ST_SEND;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_re   = (state_q == ST_DECODE);
        cmd_err = (state_q == ST_DECODE) && !cmd_known;
        tx_we   = (state_q == ST_SEND) && !tx_busy;
        busy    = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q       <= 8'h00;
            snap_q      <= 32'h0;
            unknown_q   <= 1'b0;
            idx_q       <= '0;
            tx_data_q   <= 8'h00;
            cmd_count_q <= 8'h00;
        end else begin
            if (state_q == ST_IDLE && rx_valid) begin
                cmd_q <= rx_data;
            end
            if (state_q == ST_DECODE) begin
                unknown_q <= !cmd_known;
                idx_q     <= '0;
                if (cmd_q == CMD_PC)        snap_q <= pc_in;
                else if (cmd_q == CMD_INST) snap_q <= inst_in;
                else if (cmd_q == CMD_ALU)  snap_q <= alu_in;
                else                        snap_q <= 32'h0;
            end
            if (tx_we) begin
                tx_data_q <= cur_char;
                idx_q     <= idx_q + 4'd1;
                // Count a served command once its LF actually leaves.
                if (!unknown_q && last_char) begin
                    cmd_count_q <= cmd_count_q + 8'd1;
                end
            end
        end
    end

    // Present the new character in the pulse cycle, then hold it until the next load.
    assign tx_data   = tx_we ? cur_char : tx_data_q;
    assign cmd_count = cmd_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_hex_reporter.sv
// Self-checking bench for uart_hex_reporter; build with or without UART_HEX_REPORTER_ECHO_EN.
module tb_uart_hex_reporter;
    import uart_dbg_pkg::*;

`ifdef UART_HEX_REPORTER_ECHO_EN
    localparam int KNOWN_LEN   = 12;
    localparam int UNKNOWN_LEN = 5;
`else
    localparam int KNOWN_LEN   = 10;
    localparam int UNKNOWN_LEN = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_re;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_we;
    logic [31:0] pc_in = 32'h0;
    logic [31:0] inst_in = 32'h0;
    logic [31:0] alu_in = 32'h0;
    logic        busy;
    logic        cmd_err;
    logic [7:0]  cmd_count;
    state_t      dbg_state;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_count = 8'h00;
    logic [7:0]  last_cmd = 8'h00;
    int          we_seen = 0;
    int          err_seen = 0;
    logic        prev_we = 1'b0;
    int          busy_cycles = 0;
    string       hex_digits = "0123456789ABCDEF";

    uart_hex_reporter dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_re     (rx_re),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_we     (tx_we),
        .pc_in     (pc_in),
        .inst_in   (inst_in),
        .alu_in    (alu_in),
        .busy      (busy),
        .cmd_err   (cmd_err),
        .cmd_count (cmd_count),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every transmitted byte is popped from exp_q and compared.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_we = 1'b0;
            end else begin
                if (cmd_err) err_seen++;
                if (tx_we) begin
                    we_seen++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL tx_byte: got %02h with nothing expected (cmd %02h)", tx_data, last_cmd);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx_data !== e) begin
                            bad++;
                            $display("FAIL tx_byte: got %02h expected %02h (cmd %02h)", tx_data, e, last_cmd);
                        end
                    end
                    total++;
                    if (prev_we !== 1'b0) begin
                        bad++;
                        $display("FAIL tx_we_spacing: tx_we high %0d cycles in a row, required 1", 2);
                    end
                    total++;
                    if (tx_busy !== 1'b0) begin
                        bad++;
                        $display("FAIL tx_we_busy: tx_we with tx_busy=%b, required 0", tx_busy);
                    end
                end
                prev_we = tx_we;
            end
        end
    end

    // UART transmitter model: busy for busy_cycles after each accepted byte.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            while (tx_we && busy_cycles > 0) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (busy_cycles) @(negedge clk);
                tx_busy = 1'b0;
                #3;
            end
        end
    end

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return 8'(hex_digits[n]);
    endfunction

    task automatic push_frame(input logic [7:0] cmd, input logic [31:0] val, input bit known);
        last_cmd = cmd;
`ifdef UART_HEX_REPORTER_ECHO_EN
        exp_q.push_back(cmd);
        exp_q.push_back(8'h3A);
`endif
        if (known) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(hex_ascii(val[i*4 +: 4]));
            exp_count = exp_count + 8'd1;
        end else begin
            exp_q.push_back(8'h3F);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Driver: offer one command byte, return cycles until rx_re (-1 on timeout).
    task automatic send_cmd(input logic [7:0] cmd, output int lat);
        rx_data  = cmd;
        rx_valid = 1'b1;
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            #2;
            if (rx_re) begin
                lat = i;
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        total++;
        if ({rx_re, tx_we, busy, cmd_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: rx_re/tx_we/busy/cmd_err=%b required 0000", {rx_re, tx_we, busy, cmd_err});
        end
        total++;
        if (tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_tx_data: got %02h required 00", tx_data);
        end
        total++;
        if (cmd_count !== 8'h00) begin
            bad++;
            $display("FAIL reset_cmd_count: got %02h required 00", cmd_count);
        end
        total++;
        if (dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        end
        rst = 1'b0;
    endtask

    task automatic test_pc();
        int lat;
        int base;
        bit ok;
        pc_in = 32'h0000_0040;
        busy_cycles = 0;
        base = we_seen;
        push_frame(8'h50, pc_in, 1'b1);
        send_cmd(8'h50, lat);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL pc_rx_re_latency: got %0d cycles required 1", lat);
        end
        @(negedge clk);
        #2;
        total++;
        if (tx_we !== 1'b1) begin
            bad++;
            $display("FAIL pc_first_tx_we: tx_we=%b in cycle k+2 required 1", tx_we);
        end
        wait_drain(200, ok);
        total++;
        if (!ok || we_seen - base != KNOWN_LEN) begin
            bad++;
            $display("FAIL pc_frame: drained=%0d bytes=%0d required drained=1 bytes=%0d", ok, we_seen - base, KNOWN_LEN);
        end
        total++;
        if (cmd_count !== exp_count) begin
            bad++;
            $display("FAIL pc_cmd_count: got %02h required %02h", cmd_count, exp_count);
        end
    endtask

    task automatic test_inst_busy();
        int lat;
        int base;
        bit ok;
        inst_in = 32'hDEAD_BEEF;
        busy_cycles = 20;
        base = we_seen;
        push_frame(8'h49, inst_in, 1'b1);
        send_cmd(8'h49, lat);
        wait_drain(2000, ok);
        total++;
        if (!ok || lat < 1 || we_seen - base != KNOWN_LEN) begin
            bad++;
            $display("FAIL inst_busy_frame: drained=%0d lat=%0d bytes=%0d required drained=1 bytes=%0d", ok, lat, we_seen - base, KNOWN_LEN);
        end
        total++;
        if (cmd_count !== exp_count) begin
            bad++;
            $display("FAIL inst_cmd_count: got %02h required %02h", cmd_count, exp_count);
        end
        busy_cycles = 0;
        repeat (25) @(negedge clk);
    endtask

    task automatic test_unknown();
        int lat;
        int base;
        int base_err;
        bit ok;
        base = we_seen;
        base_err = err_seen;
        push_frame(8'h78, 32'h0, 1'b0);
        send_cmd(8'h78, lat);
        wait_drain(200, ok);
        total++;
        if (!ok || lat < 1 || we_seen - base != UNKNOWN_LEN) begin
            bad++;
            $display("FAIL unknown_frame: drained=%0d lat=%0d bytes=%0d required drained=1 bytes=%0d", ok, lat, we_seen - base, UNKNOWN_LEN);
        end
        total++;
        if (err_seen - base_err != 1) begin
            bad++;
            $display("FAIL unknown_cmd_err: %0d pulses required 1", err_seen - base_err);
        end
        total++;
        if (cmd_count !== exp_count) begin
            bad++;
            $display("FAIL unknown_cmd_count: got %02h required %02h", cmd_count, exp_count);
        end
    endtask

    task automatic test_snapshot();
        int lat;
        bit ok;
        alu_in = 32'h1234_5678;
        push_frame(8'h41, alu_in, 1'b1);
        send_cmd(8'h41, lat);
        @(negedge clk);
        @(negedge clk);
        alu_in = 32'hFFFF_FFFF;
        wait_drain(200, ok);
        total++;
        if (!ok || lat < 1) begin
            bad++;
            $display("FAIL snapshot_frame: drained=%0d lat=%0d required drained=1", ok, lat);
        end
        total++;
        if (cmd_count !== exp_count) begin
            bad++;
            $display("FAIL snapshot_cmd_count: got %02h required %02h", cmd_count, exp_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        int base;
        bit ok;
        bit reached;
        pc_in = 32'hA5F0_1234;
        base = we_seen;
        push_frame(8'h50, pc_in, 1'b1);
        send_cmd(8'h50, lat);
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (we_seen - base >= 4) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
            #2;
        end
        total++;
        if (!reached) begin
            bad++;
            $display("FAIL reset_mid_progress: %0d bytes sent required 4", we_seen - base);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({rx_re, tx_we, busy, cmd_err, tx_data, cmd_count} !== 20'h0) begin
            bad++;
            $display("FAIL reset_mid_outputs: rx_re=%b tx_we=%b busy=%b cmd_err=%b tx_data=%02h cmd_count=%02h required all 0",
                     rx_re, tx_we, busy, cmd_err, tx_data, cmd_count);
        end
        exp_q.delete();
        exp_count = 8'h00;
        @(negedge clk);
        #2;
        rst = 1'b0;
        base = we_seen;
        push_frame(8'h50, pc_in, 1'b1);
        send_cmd(8'h50, lat);
        wait_drain(200, ok);
        total++;
        if (!ok || lat != 1 || we_seen - base != KNOWN_LEN) begin
            bad++;
            $display("FAIL reset_mid_new_frame: drained=%0d lat=%0d bytes=%0d required drained=1 lat=1 bytes=%0d", ok, lat, we_seen - base, KNOWN_LEN);
        end
        total++;
        if (cmd_count !== exp_count) begin
            bad++;
            $display("FAIL reset_mid_cmd_count: got %02h required %02h", cmd_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit ok;
        bit held;
        bit idle_seen;
        pc_in   = 32'h0BAD_F00D;
        inst_in = 32'h7C0F_FEE9;
        push_frame(8'h50, pc_in, 1'b1);
        push_frame(8'h49, inst_in, 1'b1);
        send_cmd(8'h50, lat);
        rx_data  = 8'h49;
        rx_valid = 1'b1;
        held = 1'b1;
        idle_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (busy === 1'b0) begin
                idle_seen = 1'b1;
                break;
            end
            if (rx_re !== 1'b0) held = 1'b0;
        end
        total++;
        if (!held || !idle_seen || rx_re !== 1'b0) begin
            bad++;
            $display("FAIL b2b_hold: held=%0d idle_seen=%0d rx_re_at_idle=%b required 1 1 0", held, idle_seen, rx_re);
        end
        @(negedge clk);
        #2;
        total++;
        if (rx_re !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: rx_re=%b one cycle after IDLE entry required 1", rx_re);
        end
        rx_valid = 1'b0;
        wait_drain(400, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_drain: drained=%0d pending=%0d required drained=1 pending=0", ok, exp_q.size());
        end
        total++;
        if (cmd_count !== exp_count) begin
            bad++;
            $display("FAIL b2b_cmd_count: got %02h required %02h", cmd_count, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_pc();
        test_inst_busy();
        test_unknown();
        test_snapshot();
        test_reset_mid_frame();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_bytes: %0d expected bytes never sent, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
